hilo_div_ctrl: RTL and testbench

- Sequencer between the EX stage and the team's 32-cycle unsigned divider (Divu), which it drives.
- Decodes DIV, DIVU, MTHI and MTLO.
- For signed divides it passes operand magnitudes to the divider and sign-corrects the results.
- Owns the architectural HI/LO registers and stalls the pipeline while a divide is in flight.

---
 rtl/hilo_div_ctrl.sv | 139 +++++++++++++
 tb/tb_hilo_div_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: sequencer between EX and the 32-cycle unsigned divider.
// Decodes DIV/DIVU/MTHI/MTLO, feeds operand magnitudes to the divider,
// sign-corrects its results and owns the architectural HI/LO registers.
// All state moves on the falling edge, the same edge the divider uses.
module hilo_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam logic [1:0] OP_DIVU = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  state_t state;
  state_t state_next;

  logic neg_q;
  logic neg_r;

  logic is_div;
  logic is_signed;
  logic rs_neg;
  logic rt_neg;
  logic rt_zero;
  logic launch;

  assign is_div    = (op == OP_DIVU) || (op == OP_DIV);
  assign is_signed = (op == OP_DIV);
  assign rs_neg    = is_signed & rs_val[WIDTH-1];
  assign rt_neg    = is_signed & rt_val[WIDTH-1];
  assign rt_zero   = (rt_val == '0);
  assign launch    = op_valid & is_div & ~rt_zero;

  // stall depends on state alone so it never forms a loop through EX
  assign stall = (state != S_IDLE);

  // State register; reset drops back to IDLE from any state
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: flush beats a WAIT completion arriving on the same edge
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (launch) begin
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_next = flush ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (flush || !div_busy) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // HI/LO, divider operands, start pulse and sign flags
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      hi           <= '0;
      lo           <= '0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            case (op)
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: begin
                if (rt_zero) begin
                  lo <= '1;
                  hi <= rs_val;
                end else begin
                  neg_q        <= is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                  neg_r        <= rs_neg;
                  div_dividend <= rs_neg ? -rs_val : rs_val;
                  div_divisor  <= rt_neg ? -rt_val : rt_val;
                  div_start    <= 1'b1;
                end
              end
            endcase
          end
        end
        S_LAUNCH: begin
          div_start <= 1'b0;
        end
        S_WAIT: begin
          div_start <= 1'b0;
          if (!flush && !div_busy) begin
            lo <= neg_q ? -div_q : div_q;
            hi <= neg_r ? -div_r : div_r;
          end
        end
        default: begin
          div_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: drives hilo_div_ctrl against a behavioural 32-cycle
// divider stand-in and compares HI/LO, stall and operand outputs with a
// reference computed from plain signed/unsigned arithmetic.
module tb_hilo_div_ctrl;

  localparam int WIDTH = 32;

  localparam logic [1:0] OP_DIVU = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  logic             clock = 1'b1;
  logic             reset;
  logic             op_valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_start;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_busy;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;

  int checks = 0;
  int errors = 0;
  int start_pulses = 0;

  logic [WIDTH-1:0] exp_hi;
  logic [WIDTH-1:0] exp_lo;

  hilo_div_ctrl #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .op_valid    (op_valid),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .flush       (flush),
    .stall       (stall),
    .hi          (hi),
    .lo          (lo),
    .div_start   (div_start),
    .div_dividend(div_dividend),
    .div_divisor (div_divisor),
    .div_busy    (div_busy),
    .div_q       (div_q),
    .div_r       (div_r)
  );

  // Free-running clock, falling edge is the active edge
  always #5 clock = ~clock;

  // Divider stand-in: samples start, stays busy for 32 edges, then presents q/r
  int               dv_cnt;
  logic [WIDTH-1:0] dv_a;
  logic [WIDTH-1:0] dv_b;
  always @(negedge clock or posedge reset) begin
    if (reset) begin
      div_busy <= 1'b0;
      dv_cnt   <= 0;
      div_q    <= '0;
      div_r    <= '0;
      dv_a     <= '0;
      dv_b     <= '1;
    end else if (div_start) begin
      div_busy <= 1'b1;
      dv_cnt   <= 32;
      dv_a     <= div_dividend;
      dv_b     <= div_divisor;
    end else if (div_busy) begin
      dv_cnt <= dv_cnt - 1;
      if (dv_cnt == 1) begin
        div_busy <= 1'b0;
        div_q    <= dv_a / dv_b;
        div_r    <= dv_a % dv_b;
      end
    end
  end

  // Count start pulses seen mid-cycle, away from the active edge
  always @(posedge clock) begin
    if (div_start === 1'b1) start_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Wait for stall to drop, bounded; returns number of active edges waited
  task automatic waitIdle(output int edges);
    edges = 0;
    while (stall === 1'b1 && edges < 100) begin
      step();
      edges++;
    end
  endtask

  // Reference divide using 64-bit arithmetic so -2^31/-1 wraps naturally
  task automatic refDiv(input logic sgn, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b,
                        output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                        output logic [WIDTH-1:0] ma, output logic [WIDTH-1:0] mb);
    longint sa, sb, q64, r64, aa, ab;
    sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    q64 = sa / sb;
    r64 = sa % sb;
    aa  = (sa < 0) ? -sa : sa;
    ab  = (sb < 0) ? -sb : sb;
    q   = q64[WIDTH-1:0];
    r   = r64[WIDTH-1:0];
    ma  = aa[WIDTH-1:0];
    mb  = ab[WIDTH-1:0];
  endtask

  // Present one op for a single cycle and check it to completion
  task automatic applyStimulus(input logic [1:0] o, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] q, r, ma, mb;
    int edges;
    int p0;
    op_valid = 1'b1;
    op       = o;
    rs_val   = a;
    rt_val   = b;
    p0       = start_pulses;
    step();
    op_valid = 1'b0;
    if (o == OP_MTHI) begin
      exp_hi = a;
      checkOutput("mthi_stall", {31'b0, stall}, 0);
      checkOutput("mthi_hi", hi, exp_hi);
      checkOutput("mthi_lo", lo, exp_lo);
    end else if (o == OP_MTLO) begin
      exp_lo = a;
      checkOutput("mtlo_stall", {31'b0, stall}, 0);
      checkOutput("mtlo_hi", hi, exp_hi);
      checkOutput("mtlo_lo", lo, exp_lo);
    end else if (b == '0) begin
      exp_lo = '1;
      exp_hi = a;
      checkOutput("div0_stall", {31'b0, stall}, 0);
      checkOutput("div0_start", {31'b0, div_start}, 0);
      checkOutput("div0_hi", hi, exp_hi);
      checkOutput("div0_lo", lo, exp_lo);
    end else begin
      refDiv(o == OP_DIV, a, b, q, r, ma, mb);
      checkOutput("div_stall_rise", {31'b0, stall}, 1);
      checkOutput("div_start_rise", {31'b0, div_start}, 1);
      checkOutput("div_dividend", div_dividend, ma);
      checkOutput("div_divisor", div_divisor, mb);
      step();
      checkOutput("div_start_drop", {31'b0, div_start}, 0);
      waitIdle(edges);
      checkOutput("div_latency", 32'(edges + 1), 34);
      checkOutput("div_pulses", 32'(start_pulses - p0), 1);
      exp_lo = q;
      exp_hi = r;
      checkOutput("div_lo", lo, exp_lo);
      checkOutput("div_hi", hi, exp_hi);
    end
    step();
  endtask

  // Directed and randomized sequence
  initial begin
    int edges;
    logic [1:0]       ro;
    logic [WIDTH-1:0] ra, rb;
    reset    = 1'b1;
    op_valid = 1'b0;
    op       = OP_DIVU;
    rs_val   = '0;
    rt_val   = '0;
    flush    = 1'b0;
    exp_hi   = '0;
    exp_lo   = '0;
    #12;
    checkOutput("rst_stall", {31'b0, stall}, 0);
    checkOutput("rst_hi", hi, 0);
    checkOutput("rst_lo", lo, 0);
    checkOutput("rst_start", {31'b0, div_start}, 0);
    checkOutput("rst_dividend", div_dividend, 0);
    checkOutput("rst_divisor", div_divisor, 0);
    reset = 1'b0;
    step();

    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(OP_DIVU, 32'h0000_1234, 32'd0);
    applyStimulus(OP_MTHI, 32'hA5A5_A5A5, 32'd0);
    applyStimulus(OP_MTLO, 32'h5A5A_5A5A, 32'd0);

    $display("[TB] MTHI during WAIT is ignored");
    op_valid = 1'b1; op = OP_DIVU; rs_val = 32'd1000; rt_val = 32'd10;
    step();
    op_valid = 1'b0;
    repeat (5) step();
    op_valid = 1'b1; op = OP_MTHI; rs_val = 32'hDEAD_BEEF;
    step();
    op_valid = 1'b0;
    checkOutput("wait_mthi_hi", hi, exp_hi);
    waitIdle(edges);
    exp_lo = 32'd100;
    exp_hi = 32'd0;
    checkOutput("wait_mthi_lo_res", lo, exp_lo);
    checkOutput("wait_mthi_hi_res", hi, exp_hi);
    step();
    applyStimulus(OP_MTHI, 32'hDEAD_BEEF, 32'd0);

    $display("[TB] flush mid-divide then new divide");
    op_valid = 1'b1; op = OP_DIVU; rs_val = 32'd50; rt_val = 32'd5;
    step();
    op_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush_stall", {31'b0, stall}, 0);
    repeat (30) step();
    checkOutput("flush_hi", hi, exp_hi);
    checkOutput("flush_lo", lo, exp_lo);
    applyStimulus(OP_DIVU, 32'd9, 32'd4);

    $display("[TB] flush on the completion edge wins");
    op_valid = 1'b1; op = OP_DIV; rs_val = 32'hFFFF_FF00; rt_val = 32'd3;
    step();
    op_valid = 1'b0;
    repeat (33) step();
    checkOutput("late_flush_stall_pre", {31'b0, stall}, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("late_flush_stall", {31'b0, stall}, 0);
    checkOutput("late_flush_hi", hi, exp_hi);
    checkOutput("late_flush_lo", lo, exp_lo);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("idle_flush_stall", {31'b0, stall}, 0);

    $display("[TB] randomized ops");
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if (rb == 32'd0 && $urandom_range(0, 1) == 1) rb = 32'd3;
      applyStimulus(ro, ra, rb);
    end

    $display("[TB] async reset mid-WAIT");
    applyStimulus(OP_MTLO, 32'h1357_9BDF, 32'd0);
    op_valid = 1'b1; op = OP_DIVU; rs_val = 32'd77; rt_val = 32'd6;
    step();
    op_valid = 1'b0;
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    checkOutput("rst_mid_stall", {31'b0, stall}, 0);
    checkOutput("rst_mid_hi", hi, exp_hi);
    checkOutput("rst_mid_lo", lo, exp_lo);
    #2 reset = 1'b0;
    step();
    applyStimulus(OP_DIVU, 32'd77, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
